weight_loader: RTL and testbench

Sequencer that writes a kernel's worth of signed weights into the accelerator's bank of weight registers. Accepts a valid/ready weight stream from the host/memory side after a start command. For each accepted weight it drives the shared data bus and a one-hot load strobe selecting exactly one weight register. It sits between the weight source and the weight-register bank of one convolution engine.

---
 rtl/wload_pkg.sv | 18 +
 rtl/weight_loader_if.sv | 11 +
 rtl/weight_loader.sv | 83 ++++++++
 tb/tb_weight_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/wload_pkg.sv
// Shared constants for the weight loader and the convolution engine wrapper.
package wload_pkg;

  localparam logic [1:0] WLOAD_IDLE = 2'd0;
  localparam logic [1:0] WLOAD_LOAD = 2'd1;
  localparam logic [1:0] WLOAD_DONE = 2'd2;

  localparam int DEF_NUM_WEIGHTS = 9;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_CNT_WIDTH   = 4;

  typedef enum logic [1:0] {
    S_IDLE = WLOAD_IDLE,
    S_LOAD = WLOAD_LOAD,
    S_DONE = WLOAD_DONE
  } wload_state_e;

endpackage

// File: rtl/weight_loader_if.sv
// Valid/ready weight stream from the source into the loader.
interface weight_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] WLOAD_In_Data;
  logic                  WLOAD_In_Valid;
  logic                  WLOAD_In_Ready;

  modport master (output WLOAD_In_Data, output WLOAD_In_Valid, input  WLOAD_In_Ready);
  modport slave  (input  WLOAD_In_Data, input  WLOAD_In_Valid, output WLOAD_In_Ready);
endinterface

// File: rtl/weight_loader.sv
// Sequences one kernel of signed weights onto the shared bus with a one-hot load strobe.
//  state  | meaning
//  IDLE   | waiting for Start, not accepting weights
//  LOAD   | accepting one weight per cycle, strobing register idx
//  DONE   | final strobe on the bus, Done pulse, back to IDLE next cycle
module weight_loader
  import wload_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NUM_WEIGHTS = DEF_NUM_WEIGHTS,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                   WLOAD_Clk,
  input  logic                   WLOAD_Reset,
  input  logic                   WLOAD_Start,
  weight_loader_if.slave         src,
  output logic [DATA_WIDTH-1:0]  WLOAD_Out_Data,
  output logic [NUM_WEIGHTS-1:0] WLOAD_Set_Bus,
  output logic                   WLOAD_Busy,
  output logic                   WLOAD_Done
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(NUM_WEIGHTS - 1);

  wload_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [NUM_WEIGHTS-1:0] set_q, set_d;

  always_ff @(posedge WLOAD_Clk or negedge WLOAD_Reset) begin
    if (!WLOAD_Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      set_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      set_q   <= set_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    set_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (WLOAD_Start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (src.WLOAD_In_Valid) begin
          data_d = src.WLOAD_In_Data;
          set_d  = NUM_WEIGHTS'(1) << idx_q;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Handshake and status come straight from the state register, never from In_Valid.
  assign src.WLOAD_In_Ready = (state_q == S_LOAD);
  assign WLOAD_Busy         = (state_q != S_IDLE);
  assign WLOAD_Done         = (state_q == S_DONE);
  assign WLOAD_Out_Data     = data_q;
  assign WLOAD_Set_Bus      = set_q;

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader with a negedge-capturing register bank model.
module tb_weight_loader;
  import wload_pkg::*;

  localparam int DW = 16;
  localparam int NW = 9;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] out_data;
  logic [NW-1:0] set_bus;
  logic          busy;
  logic          done;

  weight_loader_if #(.DATA_WIDTH(DW)) src_if ();

  weight_loader #(.DATA_WIDTH(DW), .NUM_WEIGHTS(NW), .CNT_WIDTH(4)) dut (
    .WLOAD_Clk      (clk),
    .WLOAD_Reset    (rst_n),
    .WLOAD_Start    (start),
    .src            (src_if.slave),
    .WLOAD_Out_Data (out_data),
    .WLOAD_Set_Bus  (set_bus),
    .WLOAD_Busy     (busy),
    .WLOAD_Done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Weight register bank: captures on negedge inside the strobe window.
  logic [DW-1:0] bank [NW];
  int strobe_cnt = 0;
  int done_cnt   = 0;
  bit multi_hot  = 1'b0;

  always @(negedge clk) begin
    if (set_bus != '0) strobe_cnt++;
    if ($countones(set_bus) > 1) multi_hot = 1'b1;
    if (done) done_cnt++;
    for (int i = 0; i < NW; i++)
      if (set_bus[i]) bank[i] = out_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("start_ready", 32'(src_if.WLOAD_In_Ready), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input int bit_i);
    src_if.WLOAD_In_Data  = w;
    src_if.WLOAD_In_Valid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk($sformatf("strobe%0d", bit_i), 32'(set_bus), 32'd1 << bit_i);
    chk($sformatf("data%0d", bit_i), 32'(out_data), 32'(w));
  endtask

  task automatic gap_cycle();
    src_if.WLOAD_In_Valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("gap_strobe", 32'(set_bus), 32'd0);
  endtask

  // Called at the negedge right after the last transfer.
  task automatic finish_seq();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_ready", 32'(src_if.WLOAD_In_Ready), 32'd0);
    src_if.WLOAD_In_Valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_strobe", 32'(set_bus), 32'd0);
  endtask

  logic [DW-1:0] w3 [NW];
  int s0, d0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    src_if.WLOAD_In_Data  = '0;
    src_if.WLOAD_In_Valid = 1'b0;
    #12;
    chk("rst_set", 32'(set_bus), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(src_if.WLOAD_In_Ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: back-to-back 1..9
    s0 = strobe_cnt; d0 = done_cnt;
    do_start();
    for (int i = 0; i < NW; i++) send_word(DW'(i + 1), i);
    finish_seq();
    chk("t1_strobes", 32'(strobe_cnt - s0), 32'd9);
    chk("t1_dones", 32'(done_cnt - d0), 32'd1);
    for (int i = 0; i < NW; i++) chk($sformatf("t1_bank%0d", i), 32'(bank[i]), 32'(i + 1));

    // 2: gaps of two cycles after weights 3 and 7
    s0 = strobe_cnt;
    do_start();
    for (int i = 0; i < NW; i++) begin
      send_word(DW'(16'h0100 + i), i);
      if (i == 2 || i == 6) begin
        gap_cycle();
        gap_cycle();
      end
    end
    finish_seq();
    chk("t2_strobes", 32'(strobe_cnt - s0), 32'd9);
    for (int i = 0; i < NW; i++) chk($sformatf("t2_bank%0d", i), 32'(bank[i]), 32'(16'h0100 + i));

    // 3: negative and extreme weights
    w3[0] = 16'hFFFF; w3[1] = 16'h8000; w3[2] = 16'h7FFF;
    w3[3] = 16'h0000; w3[4] = 16'hFFFE; w3[5] = 16'h0001;
    w3[6] = 16'h8001; w3[7] = 16'h1234; w3[8] = 16'hEDCC;
    do_start();
    for (int i = 0; i < NW; i++) send_word(w3[i], i);
    finish_seq();
    chk("t3_neg1", 32'($signed(bank[0])), 32'hFFFF_FFFF);
    chk("t3_min", 32'($signed(bank[1])), 32'hFFFF_8000);
    chk("t3_max", 32'($signed(bank[2])), 32'h0000_7FFF);
    chk("t3_last", 32'($signed(bank[8])), 32'hFFFF_EDCC);

    // 4: Start asserted mid-LOAD and held through DONE
    s0 = strobe_cnt;
    do_start();
    for (int i = 0; i < 4; i++) send_word(DW'(16'h0200 + i), i);
    start = 1'b1;
    for (int i = 4; i < NW; i++) send_word(DW'(16'h0200 + i), i);
    chk("t4_done", 32'(done), 32'd1);
    src_if.WLOAD_In_Valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("t4_idle_busy", 32'(busy), 32'd0);
    chk("t4_idle_ready", 32'(src_if.WLOAD_In_Ready), 32'd0);
    chk("t4_strobes", 32'(strobe_cnt - s0), 32'd9);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("t4_restart_ready", 32'(src_if.WLOAD_In_Ready), 32'd1);
    for (int i = 0; i < NW; i++) send_word(DW'(16'h0300 + i), i);
    finish_seq();

    // 5: reset after weight 5
    do_start();
    for (int i = 0; i < 5; i++) send_word(DW'(16'h0400 + i), i);
    #2 rst_n = 1'b0;
    src_if.WLOAD_In_Valid = 1'b0;
    #1;
    chk("t5_rst_set", 32'(set_bus), 32'd0);
    chk("t5_rst_data", 32'(out_data), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(src_if.WLOAD_In_Ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    for (int i = 0; i < NW; i++) send_word(DW'(16'h0500 + i), i);
    finish_seq();

    // 6: Valid high in IDLE without Start
    s0 = strobe_cnt;
    src_if.WLOAD_In_Data  = 16'hABCD;
    src_if.WLOAD_In_Valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk("t6_ready", 32'(src_if.WLOAD_In_Ready), 32'd0);
      chk("t6_strobe", 32'(set_bus), 32'd0);
    end
    chk("t6_strobes", 32'(strobe_cnt - s0), 32'd0);
    do_start();
    send_word(16'hABCD, 0);
    for (int i = 1; i < NW; i++) send_word(DW'(16'h0600 + i), i);
    finish_seq();
    chk("t6_bank0", 32'(bank[0]), 32'h0000_ABCD);

    chk("never_multi_hot", 32'(multi_hot), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end, required finish");
    $fatal(1);
  end

endmodule
